// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side streaming block.
//   DW_DEF    : default data width (matches upstream FIFO read width)
//   DEPTH_DEF : default output buffer depth (power of 2, >= 4)
//   CW_DEF    : default beat-counter width
//   PTR_W     : buffer index width for the default depth, log2(DEPTH_DEF)
package fifo_pkg;

    localparam int unsigned DW_DEF    = 64;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CW_DEF    = 32;

    // Index width for a buffer of the given depth; pointers carry one extra wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned PTR_W = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/ccnt.sv
// Wrapping up-counter with enable.
//   clk  : clock
//   rstn : asynchronous active-low reset, clears the count
//   en   : increment by one on this edge
//   cnt  : current count, wraps from 2^W-1 to 0
module ccnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an upstream FIFO read port (1-cycle read latency) into a small
// output buffer and presents it as a valid/ready stream.
//   clk, rstn   : clock (shared with upstream rclk), async active-low reset
//   fifo_rempty : upstream empty flag
//   fifo_rinc   : upstream pop request (never asserted while empty)
//   fifo_rdata  : upstream data, valid the cycle after an accepted pop
//   m_valid     : stream valid, head entry present
//   m_ready     : stream ready
//   m_data      : stream data, taken straight from the head entry
//   flush       : synchronous clear of buffered and in-flight data
//   beat_cnt    : number of beats delivered, wrapping
//   level       : buffer occupancy, 0..DEPTH
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CW    = CW_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   fifo_rempty,
    output logic                   fifo_rinc,
    input  logic [DW-1:0]          fifo_rdata,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DW-1:0]          m_data,
    input  logic                   flush,
    output logic [CW-1:0]          beat_cnt,
    output logic [ptr_w(DEPTH):0]  level
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned LW = AW + 1;

    // Pointers are AW index bits plus one wrap bit.
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic [LW-1:0] level_c;
    logic [LW:0]   occ_c;
    logic          room_c;
    logic          xfer_c;

    // Occupancy from wrap-bit pointers: equal means empty, DEPTH means full.
    assign level_c = wptr_q - rptr_q;
    assign occ_c   = (LW+1)'(level_c) + (LW+1)'(inflight_q);
    assign room_c  = occ_c < (LW+1)'(DEPTH);

    // Pop is combinational so flush, empty and reset suppress it in the same cycle.
    assign fifo_rinc = rstn && !fifo_rempty && !flush && room_c;

    assign m_valid = (wptr_q != rptr_q);
    assign m_data  = mem_q[rptr_q[AW-1:0]];
    assign xfer_c  = m_valid && m_ready;
    assign level   = level_c;

    // Next-state for pointers and the in-flight pop marker.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = fifo_rinc;
        if (inflight_q) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (xfer_c) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
        // Flush drops buffered data and the data returning for last cycle's pop.
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage captures read data the cycle after the pop; no reset needed.
    always_ff @(posedge clk) begin
        if (inflight_q && !flush) begin
            mem_q[wptr_q[AW-1:0]] <= fifo_rdata;
        end
    end

    // Beat counter advances on every transfer, including one during flush.
    ccnt #(
        .W(CW)
    ) u_beat_cnt (
        .clk (clk),
        .rstn(rstn),
        .en  (xfer_c),
        .cnt (beat_cnt)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised and directed bench for fifo_rd_stream against a queue-level model.
module tb_fifo_rd_stream;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = fifo_pkg::DEPTH_DEF;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = fifo_pkg::PTR_W + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fifo_rempty = 1'b1;
    logic          fifo_rinc;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          flush = 1'b0;
    logic [CW-1:0] beat_cnt;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .beat_cnt   (beat_cnt),
        .level      (level)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: upstream words, words in the buffer, word returning next cycle.
    logic [DW-1:0] up_q[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] pend_d = '0;
    bit            pend_v = 1'b0;
    int            bcnt = 0;
    bit            force_empty = 1'b0;
    logic [DW-1:0] next_word = DW'(1);

    int cyc = 0;
    int n_pop, n_xfer, first_pop, first_valid, first_x, last_x;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive_up();
        fifo_rempty = (up_q.size() == 0) || force_empty;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            up_q.push_back(next_word);
            next_word = next_word + DW'(1);
        end
        drive_up();
    endtask

    task automatic reset_track();
        n_pop = 0; n_xfer = 0;
        first_pop = -1; first_valid = -1; first_x = -1; last_x = -1;
    endtask

    // One clock cycle: check at negedge, advance model at posedge, drive at posedge+1.
    task automatic step();
        bit acc, xfer, exp_rinc;
        @(negedge clk);
        chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
        chk("level", 64'(level), 64'(mq.size()));
        if (mq.size() != 0) chk("m_data", 64'(m_data), 64'(mq[0]));
        chk("beat_cnt", 64'(beat_cnt), 64'(bcnt % (1 << CW)));
        exp_rinc = rstn && !fifo_rempty && !flush && (mq.size() + int'(pend_v) < int'(DEPTH));
        chk("fifo_rinc", 64'(fifo_rinc), 64'(exp_rinc));
        acc  = fifo_rinc && !fifo_rempty;
        xfer = (mq.size() != 0) && m_ready && rstn;
        if (acc) begin
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (xfer) begin
            n_xfer++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        @(posedge clk);
        if (rstn) begin
            if (xfer) begin
                void'(mq.pop_front());
                bcnt++;
            end
            if (flush) begin
                mq.delete();
                pend_v = 1'b0;
            end else begin
                if (pend_v) mq.push_back(pend_d);
                pend_v = acc && (up_q.size() != 0);
                if (pend_v) pend_d = up_q.pop_front();
            end
        end
        cyc++;
        #1;
        fifo_rdata = pend_v ? pend_d : DW'($urandom);
        drive_up();
    endtask

    // Asynchronous reset pulse in mid-cycle, held for two edges.
    task automatic pulse_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_fifo_rinc", 64'(fifo_rinc), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        mq.delete();
        pend_v = 1'b0;
        bcnt = 0;
        repeat (2) step();
        #2 rstn = 1'b1;
    endtask

    initial begin
        bit found;
        int rem;

        #2;
        chk("init_m_valid", 64'(m_valid), 64'(0));
        chk("init_fifo_rinc", 64'(fifo_rinc), 64'(0));
        chk("init_level", 64'(level), 64'(0));
        chk("init_beat_cnt", 64'(beat_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Steady state: 8 words, always ready.
        m_ready = 1'b1;
        push_words(8);
        reset_track();
        repeat (14) step();
        chk("ss_valid_latency", 64'(first_valid - first_pop), 64'(2));
        chk("ss_back_to_back", 64'(last_x - first_x), 64'(7));
        chk("ss_beats", 64'(n_xfer), 64'(8));
        chk("ss_beat_cnt", 64'(beat_cnt), 64'(8));

        // Backpressure: only DEPTH pops, then everything drains in order.
        m_ready = 1'b0;
        push_words(10);
        reset_track();
        repeat (10) step();
        chk("bp_pops", 64'(n_pop), 64'(4));
        chk("bp_level", 64'(level), 64'(4));
        reset_track();
        repeat (5) step();
        chk("bp_no_more_pops", 64'(n_pop), 64'(0));
        m_ready = 1'b1;
        reset_track();
        repeat (20) step();
        chk("bp_delivered", 64'(n_xfer), 64'(10));

        // Near empty: a single word.
        reset_track();
        repeat (3) step();
        push_words(1);
        repeat (8) step();
        chk("ne_pops", 64'(n_pop), 64'(1));
        chk("ne_beats", 64'(n_xfer), 64'(1));

        // Flush the cycle after a pop with three entries buffered.
        m_ready = 1'b0;
        push_words(8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (level == LW'(3) && pend_v) found = 1'b1;
        end
        chk("fl_setup", 64'(found), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_level", 64'(level), 64'(0));
        chk("fl_m_valid", 64'(m_valid), 64'(0));
        rem = up_q.size();
        m_ready = 1'b1;
        reset_track();
        repeat (20) step();
        chk("fl_delivered", 64'(n_xfer), 64'(rem));

        // Reset mid-stream with two entries buffered.
        m_ready = 1'b0;
        push_words(6);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (level == LW'(2)) found = 1'b1;
        end
        chk("rs_setup", 64'(found), 64'(1));
        pulse_reset();
        rem = up_q.size();
        m_ready = 1'b1;
        reset_track();
        repeat (20) step();
        chk("rs_delivered", 64'(n_xfer), 64'(rem));

        // Counter wrap: 18 transfers from zero on a 4-bit counter.
        pulse_reset();
        push_words(18);
        reset_track();
        repeat (26) step();
        chk("wrap_beats", 64'(n_xfer), 64'(18));
        chk("wrap_beat_cnt", 64'(beat_cnt), 64'(2));

        // Random traffic with stalls, upstream gaps and occasional flush.
        for (int i = 0; i < 1500; i++) begin
            m_ready     = ($urandom % 4) != 0;
            flush       = ($urandom % 40) == 0;
            force_empty = ($urandom % 5) == 0;
            if (($urandom % 3) == 0) push_words(1 + int'($urandom % 3));
            drive_up();
            step();
        end
        flush = 1'b0;
        force_empty = 1'b0;
        m_ready = 1'b1;
        drive_up();
        for (int i = 0; i < 300 && (up_q.size() != 0 || mq.size() != 0 || pend_v); i++) step();
        chk("final_drained", 64'(up_q.size() + mq.size() + int'(pend_v)), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
